// File: rtl/gpu_pll_reset_ctrl.sv
// gpu_pll_reset_ctrl: PLL reset/lock sequencer on the 50 MHz refclk.
// Holds gpu_rst until PLL lock has been stable for a set time.
module gpu_pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_reset_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       gpu_rst,
  output logic       ready,
  output logic       lock_timeout,
  output logic [7:0] relock_count
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                         PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ?
                         MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          lk;
  logic          pll_rst_q, gpu_rst_q, ready_q;
  logic          lock_to_q, lock_to_d;
  logic [7:0]    relock_q, relock_d;

  assign lk = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    lock_to_d = lock_to_q;
    relock_d  = relock_q;
    if (sw_reset_req) begin
      state_d   = S_PLL_RESET;
      cnt_d     = '0;
      lock_to_d = 1'b0;
    end else begin
      unique case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // lock seen on the timeout cycle still wins
          if (lk) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d   = S_PLL_RESET;
            cnt_d     = '0;
            lock_to_d = 1'b1;
          end
        end
        S_STABILIZE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d  = S_PLL_RESET;
            cnt_d    = '0;
            relock_d = (relock_q == 8'hFF) ?
                       relock_q : relock_q + 8'd1;
          end
        end
        default: begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      gpu_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      lock_to_q <= 1'b0;
      relock_q  <= 8'd0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= (state_d == S_PLL_RESET);
      gpu_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      lock_to_q <= lock_to_d;
      relock_q  <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign gpu_rst      = gpu_rst_q;
  assign ready        = ready_q;
  assign lock_timeout = lock_to_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_gpu_pll_reset_ctrl.sv
// tb_gpu_pll_reset_ctrl: directed + random bench for the PLL sequencer.
// Reference model tracks phase and time-since-entry per clock edge.
module tb_gpu_pll_reset_ctrl;

  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_TO  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, gpu_rst, ready, lock_timeout;
  logic [7:0] relock_count;
  logic [11:0] dut_vec;

  int checks = 0;
  int failures = 0;

  gpu_pll_reset_ctrl #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_STABLE_CYCLES(P_STB),
    .LOCK_TIMEOUT_CYCLES(P_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_reset_req(sw_reset_req),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .gpu_rst(gpu_rst),
    .ready(ready),
    .lock_timeout(lock_timeout),
    .relock_count(relock_count)
  );

  always #10 clk = ~clk;

  assign dut_vec = {pll_rst, gpu_rst, ready, lock_timeout, relock_count};

  typedef enum {M_RESET, M_WAIT, M_STAB, M_RUN} mph_e;
  mph_e m_ph, m_nx;
  int   m_cyc, m_entry, m_age, m_rc;
  bit   m_to, m_h0, m_h1, m_lk, m_enter;

  // lk is pll_locked as seen two edges back
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = M_RESET; m_cyc = 0; m_entry = 0;
      m_rc = 0; m_to = 0; m_h0 = 0; m_h1 = 0;
    end else begin
      m_lk = m_h1; m_h1 = m_h0; m_h0 = pll_locked;
      m_age = m_cyc - m_entry;
      m_cyc++;
      m_nx = m_ph;
      m_enter = 0;
      if (sw_reset_req) begin
        m_to = 0; m_nx = M_RESET; m_enter = 1;
      end else begin
        case (m_ph)
          M_RESET: if (m_age >= P_RST - 1) begin
            m_nx = M_WAIT; m_enter = 1;
          end
          M_WAIT: if (m_lk) begin
            m_nx = M_STAB; m_enter = 1;
          end else if (m_age >= P_TO - 1) begin
            m_to = 1; m_nx = M_RESET; m_enter = 1;
          end
          M_STAB: if (!m_lk) begin
            m_nx = M_WAIT; m_enter = 1;
          end else if (m_age >= P_STB - 1) begin
            m_nx = M_RUN; m_enter = 1;
          end
          M_RUN: if (!m_lk) begin
            if (m_rc < 255) m_rc++;
            m_nx = M_RESET; m_enter = 1;
          end
        endcase
      end
      if (m_enter) m_entry = m_cyc;
      m_ph = m_nx;
    end
  end

  function automatic logic [11:0] exp_vec();
    return {m_ph == M_RESET, m_ph != M_RUN, m_ph == M_RUN,
            m_to, 8'(m_rc)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    sw_reset_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== 12'hC00) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=c00", dut_vec);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_power_up();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL pwr_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (pll_rst !== (k == 2)) begin
          failures++;
          $display("FAIL pwr_pll_rst k=%0d got=%b exp=%b", k, pll_rst, k == 2);
        end
      end
      if (k == 20 || k == 21) begin
        checks++;
        if (ready !== (k == 21) || gpu_rst !== (k == 20)) begin
          failures++;
          $display("FAIL pwr_release k=%0d got=%b%b exp=%b%b",
                   k, ready, gpu_rst, k == 21, k == 20);
        end
      end
      if (k == 10) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL to_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 34 || k == 35) begin
        checks++;
        if (lock_timeout !== (k == 35) || pll_rst !== (k == 35)) begin
          failures++;
          $display("FAIL to_flag k=%0d got=%b%b exp=%b%b",
                   k, lock_timeout, pll_rst, k == 35, k == 35);
        end
      end
      if (k == 38 || k == 39 || k == 70 || k == 71) begin
        checks++;
        if (pll_rst !== (k == 38 || k == 71)) begin
          failures++;
          $display("FAIL to_pulse k=%0d got=%b", k, pll_rst);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL gl_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k >= 4 && pll_rst !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL gl_pll_rst k=%0d got=1 exp=0", k);
      end
      if (k == 26 || k == 27) begin
        checks++;
        if (ready !== (k == 27)) begin
          failures++;
          $display("FAIL gl_release k=%0d got=%b exp=%b", k, ready, k == 27);
        end
      end
      if (k == 10) pll_locked = 1'b1;
      if (k == 15) pll_locked = 1'b0;
      if (k == 16) pll_locked = 1'b1;
    end
  endtask

  task automatic test_lock_loss();
    int n;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL loss_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 27 || k == 28) begin
        checks++;
        if (ready !== (k == 27) || relock_count !== 8'(k - 27) ||
            pll_rst !== (k == 28)) begin
          failures++;
          $display("FAIL loss_edge k=%0d got=%b%b %0d", k, ready,
                   pll_rst, relock_count);
        end
      end
      if (k == 10) pll_locked = 1'b1;
      if (k == 25) pll_locked = 1'b0;
    end
    for (int i = 1; i < 300; i++) begin
      pll_locked = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL sat_model i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
        end
      end while (ready !== 1'b1 && n < 100);
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL sat_run_timeout i=%0d got=%b exp=1", i, ready);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pll_locked = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ready !== 1'b0 && n < 10);
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL sat_drop_timeout i=%0d got=%b exp=0", i, ready);
      end
    end
    checks++;
    if (relock_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=255", relock_count);
    end
  endtask

  task automatic test_async_rst();
    int n;
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_rst !== 1'b0 && n < 20);
    checks++;
    if (pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL ar_wait got=%b exp=0", pll_rst);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec() || m_ph != M_STAB || relock_count !== 8'd255) begin
      failures++;
      $display("FAIL ar_pre got=%h exp=%h", dut_vec, exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 12'hC00 || dut.sync_q !== 2'b00) begin
      failures++;
      $display("FAIL ar_async got=%h sync=%b exp=c00 sync=00",
               dut_vec, dut.sync_q);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL ar_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 11 || k == 12) begin
        checks++;
        if (ready !== (k == 12)) begin
          failures++;
          $display("FAIL ar_release k=%0d got=%b exp=%b", k, ready, k == 12);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    do_reset();
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL sw_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 57) begin
        checks++;
        if (lock_timeout !== 1'b1 || ready !== 1'b1) begin
          failures++;
          $display("FAIL sw_pre got=%b%b exp=11", lock_timeout, ready);
        end
      end
      if (k == 58) begin
        checks++;
        if (pll_rst !== 1'b1 || lock_timeout !== 1'b0 ||
            relock_count !== 8'd0) begin
          failures++;
          $display("FAIL sw_run got=%b%b %0d exp=10 0", pll_rst,
                   lock_timeout, relock_count);
        end
      end
      if (k == 64 || k == 65) begin
        checks++;
        if (pll_rst !== (k == 64)) begin
          failures++;
          $display("FAIL sw_restart k=%0d got=%b exp=%b", k, pll_rst, k == 64);
        end
      end
      if (k == 40) pll_locked = 1'b1;
      if (k == 55) pll_locked = 1'b0;
      sw_reset_req = (k == 57 || k == 60);
    end
  endtask

  task automatic test_random();
    int run;
    do_reset();
    run = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rnd_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (run == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        run = $urandom_range(1, 60);
      end
      run--;
      sw_reset_req = ($urandom_range(0, 199) == 0);
    end
    sw_reset_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_async_rst();
    test_sw_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
